m68k_bus_target: RTL and testbench

Synchronous 68000-bus responder that sits on the CPU side of the system bus, opposite the TG68K bus-wrapper master. It recognises a bus cycle when `as_n` falls, handles three cases, and terminates each with the matching 68000 signal:
- Ordinary reads and writes: forwarded to a simple req/ack memory backend, terminated with `dtack_n` after a programmable wait-state count.
- Interrupt-acknowledge cycles: answered with `vpa_n` (autovector).
- Unclaimed cycles: terminated with `berr` after a timeout.

---
 rtl/m68k_bus_target.sv | 214 +++++++++++++++++++++
 tb/tb_m68k_bus_target.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: forwards selected cycles to a req/ack backend, answers IACK with
// VPA (autovector) and terminates unclaimed cycles with BERR after a timeout.
module m68k_bus_target #(
   parameter int unsigned WAIT_STATES  = 2,
   parameter int unsigned BERR_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        as_n,
   input  logic        rw_n,
   input  logic        uds_n,
   input  logic        lds_n,
   input  logic [2:0]  fc,
   input  logic [22:0] addr,
   input  logic        cs,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        dout_oe,
   output logic        dtack_n,
   output logic        vpa_n,
   output logic        berr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [22:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STROBE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_UNSEL,
      S_BERRH
   } state_t;

   localparam logic [7:0] C_WAIT = 8'(WAIT_STATES);
   localparam logic [7:0] C_TMO  = 8'(BERR_TIMEOUT);

   state_t      r_state, w_state_nxt;
   logic        r_as_d;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic        r_abort, w_abort_nxt;
   logic        r_dtack_n, w_dtack_n_nxt;
   logic        r_vpa_n, w_vpa_n_nxt;
   logic        r_berr, w_berr_nxt;
   logic        r_mem_req, w_mem_req_nxt;
   logic        r_mem_we, w_mem_we_nxt;
   logic [1:0]  r_mem_be, w_mem_be_nxt;
   logic [22:0] r_mem_addr, w_mem_addr_nxt;
   logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [15:0] r_dout, w_dout_nxt;
   logic        r_dout_oe, w_dout_oe_nxt;

   logic        w_start;
   logic        w_strobe;
   logic [7:0]  w_cnt_inc;

   assign w_start   = ~as_n & r_as_d;
   assign w_strobe  = ~(uds_n & lds_n);
   assign w_cnt_inc = r_cnt + 8'd1;

   always_comb begin
      // NOTE: every next value defaults to its register so no path through the case infers a latch.
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_abort_nxt     = r_abort;
      w_dtack_n_nxt   = r_dtack_n;
      w_vpa_n_nxt     = r_vpa_n;
      w_berr_nxt      = r_berr;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_be_nxt    = r_mem_be;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_dout_nxt      = r_dout;
      w_dout_oe_nxt   = r_dout_oe;

      unique case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (fc == 3'b111) begin
                  w_vpa_n_nxt = 1'b0;
                  w_state_nxt = S_HOLD;
               end else if (cs) begin
                  w_state_nxt = S_STROBE;
               end else begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = S_UNSEL;
               end
            end
         end
         S_STROBE: begin
            // Writes present their strobes late, so the backend access waits for them.
            if (as_n) begin
               w_state_nxt = S_IDLE;
            end else if (w_strobe) begin
               w_mem_addr_nxt  = addr;
               w_mem_we_nxt    = ~rw_n;
               w_mem_be_nxt    = ~{uds_n, lds_n};
               w_mem_wdata_nxt = din;
               w_mem_req_nxt   = 1'b1;
               w_abort_nxt     = 1'b0;
               w_state_nxt     = S_REQ;
            end
         end
         S_REQ: begin
            if (as_n) w_abort_nxt = 1'b1;
            if (mem_ack) begin
               w_mem_req_nxt = 1'b0;
               if (!r_mem_we) w_dout_nxt = mem_rdata;
               if (r_abort || as_n) begin
                  w_state_nxt = S_IDLE;
               end else if (C_WAIT == 8'd0) begin
                  w_dtack_n_nxt = 1'b0;
                  w_dout_oe_nxt = ~r_mem_we;
                  w_state_nxt   = S_HOLD;
               end else begin
                  w_cnt_nxt   = C_WAIT;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (as_n) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == 8'd1) begin
               w_dtack_n_nxt = 1'b0;
               w_dout_oe_nxt = ~r_mem_we;
               w_state_nxt   = S_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_HOLD: begin
            if (as_n) begin
               w_dtack_n_nxt = 1'b1;
               w_vpa_n_nxt   = 1'b1;
               w_dout_oe_nxt = 1'b0;
               w_state_nxt   = S_IDLE;
            end
         end
         S_UNSEL: begin
            if (as_n) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == C_TMO) begin
                  w_berr_nxt  = 1'b1;
                  w_state_nxt = S_BERRH;
               end
            end
         end
         S_BERRH: begin
            if (as_n) begin
               w_berr_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_as_d      <= 1'b1;
         r_cnt       <= 8'd0;
         r_abort     <= 1'b0;
         r_dtack_n   <= 1'b1;
         r_vpa_n     <= 1'b1;
         r_berr      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 2'b00;
         r_mem_addr  <= 23'd0;
         r_mem_wdata <= 16'd0;
         r_dout      <= 16'd0;
         r_dout_oe   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_as_d      <= as_n;
         r_cnt       <= w_cnt_nxt;
         r_abort     <= w_abort_nxt;
         r_dtack_n   <= w_dtack_n_nxt;
         r_vpa_n     <= w_vpa_n_nxt;
         r_berr      <= w_berr_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_be    <= w_mem_be_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_dout      <= w_dout_nxt;
         r_dout_oe   <= w_dout_oe_nxt;
      end
   end

   assign dout      = r_dout;
   assign dout_oe   = r_dout_oe;
   assign dtack_n   = r_dtack_n;
   assign vpa_n     = r_vpa_n;
   assign berr      = r_berr;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_be    = r_mem_be;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: directed and random bus cycles against a shadow memory and
// edge-count timing expectations derived from the bus rules.
module tb_m68k_bus_target;

   localparam int WS  = 2;
   localparam int TMO = 8;

   logic        clk;
   logic        reset_n;
   logic        as_n;
   logic        rw_n;
   logic        uds_n;
   logic        lds_n;
   logic [2:0]  fc;
   logic [22:0] addr;
   logic        cs;
   logic [15:0] din;
   logic [15:0] dout;
   logic        dout_oe;
   logic        dtack_n;
   logic        vpa_n;
   logic        berr;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_be;
   logic [22:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   int n_cmp = 0;
   int n_err = 0;
   int ack_dly_g = 0;

   logic [15:0] model_mem   [16];
   logic [15:0] backend_mem [16];

   m68k_bus_target #(.WAIT_STATES(WS), .BERR_TIMEOUT(TMO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .as_n      (as_n),
      .rw_n      (rw_n),
      .uds_n     (uds_n),
      .lds_n     (lds_n),
      .fc        (fc),
      .addr      (addr),
      .cs        (cs),
      .din       (din),
      .dout      (dout),
      .dout_oe   (dout_oe),
      .dtack_n   (dtack_n),
      .vpa_n     (vpa_n),
      .berr      (berr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Backend: acknowledges a request ack_dly_g cycles after first seeing it.
   initial begin
      bit pend;
      int cnt;
      pend      = 1'b0;
      cnt       = 0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         mem_ack = 1'b0;
         if (!reset_n) begin
            pend = 1'b0;
         end else if (mem_req) begin
            if (!pend) begin
               pend = 1'b1;
               cnt  = ack_dly_g;
            end
            if (cnt == 0) begin
               mem_ack   = 1'b1;
               pend      = 1'b0;
               mem_rdata = backend_mem[mem_addr[3:0]];
               if (mem_we) begin
                  if (mem_be[1]) backend_mem[mem_addr[3:0]][15:8] = mem_wdata[15:8];
                  if (mem_be[0]) backend_mem[mem_addr[3:0]][7:0]  = mem_wdata[7:0];
               end
            end else begin
               cnt--;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_bus();
      as_n  = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      cs    = 1'b0;
      tick();
      check("rel_dtack_n", dtack_n, 1'b1);
      check("rel_vpa_n",   vpa_n,   1'b1);
      check("rel_berr",    berr,    1'b0);
      check("rel_dout_oe", dout_oe, 1'b0);
      tick();
   endtask

   // One selected access; d = clocks after as_n before strobes appear, ak = backend ack delay.
   task automatic do_access(input bit rd, input logic [22:0] a, input logic [1:0] be,
                            input logic [15:0] wd, input int d, input int ak);
      int req_e, ack_e, dt_e;
      logic [15:0] exp_rd;
      req_e  = (d < 1) ? 1 : d;
      ack_e  = req_e + 1 + ak;
      dt_e   = ack_e + WS;
      exp_rd = model_mem[a[3:0]];
      if (!rd) begin
         if (be[1]) model_mem[a[3:0]][15:8] = wd[15:8];
         if (be[0]) model_mem[a[3:0]][7:0]  = wd[7:0];
      end
      ack_dly_g = ak;
      fc        = 3'($urandom_range(0, 6));
      cs        = 1'b1;
      addr      = a;
      rw_n      = rd;
      din       = wd;
      as_n      = 1'b0;
      if (d == 0) {uds_n, lds_n} = ~be;
      else        {uds_n, lds_n} = 2'b11;
      for (int n = 0; n <= dt_e; n++) begin
         tick();
         check("acc_mem_req", mem_req, (n >= req_e && n < ack_e));
         check("acc_dtack_n", dtack_n, (n < dt_e));
         if (n == req_e) begin
            check("acc_mem_we",   mem_we,   !rd);
            check("acc_mem_be",   mem_be,   be);
            check("acc_mem_addr", mem_addr, a);
            if (!rd) check("acc_mem_wdata", mem_wdata, wd);
         end
         if (n == dt_e) begin
            check("acc_dout_oe", dout_oe, rd);
            if (rd) check("acc_dout", dout, exp_rd);
            check("acc_vpa_n", vpa_n, 1'b1);
            check("acc_berr",  berr,  1'b0);
         end
         if (d > 0 && n == d - 1) {uds_n, lds_n} = ~be;
      end
   endtask

   initial begin
      int hold;
      for (int i = 0; i < 16; i++) begin
         model_mem[i]   = 16'($urandom);
         backend_mem[i] = model_mem[i];
      end
      reset_n = 1'b0;
      as_n    = 1'b1;
      rw_n    = 1'b1;
      uds_n   = 1'b1;
      lds_n   = 1'b1;
      fc      = 3'd0;
      addr    = 23'd0;
      cs      = 1'b0;
      din     = 16'd0;

      tick();
      tick();
      check("rst_dtack_n",   dtack_n,   1'b1);
      check("rst_vpa_n",     vpa_n,     1'b1);
      check("rst_berr",      berr,      1'b0);
      check("rst_mem_req",   mem_req,   1'b0);
      check("rst_mem_we",    mem_we,    1'b0);
      check("rst_mem_be",    mem_be,    2'b00);
      check("rst_dout",      dout,      16'h0000);
      check("rst_dout_oe",   dout_oe,   1'b0);
      check("rst_mem_addr",  mem_addr,  23'd0);
      check("rst_mem_wdata", mem_wdata, 16'h0000);
      reset_n = 1'b1;
      tick();

      // Word read returning BEEF, ack one clock after the request.
      model_mem[4'h3]   = 16'hBEEF;
      backend_mem[4'h3] = 16'hBEEF;
      do_access(1'b1, 23'h012343, 2'b11, 16'h0000, 0, 0);
      release_bus();

      // Lower-byte write with strobes two clocks after as_n.
      do_access(1'b0, 23'h000045, 2'b01, 16'h00A5, 2, 0);
      release_bus();
      do_access(1'b1, 23'h000045, 2'b11, 16'h0000, 0, 1);
      release_bus();

      // Interrupt acknowledge.
      fc    = 3'b111;
      cs    = 1'b0;
      rw_n  = 1'b1;
      uds_n = 1'b0;
      lds_n = 1'b0;
      as_n  = 1'b0;
      hold  = $urandom_range(2, 5);
      for (int n = 0; n <= hold; n++) begin
         tick();
         check("iack_vpa_n",   vpa_n,   1'b0);
         check("iack_mem_req", mem_req, 1'b0);
         check("iack_dtack_n", dtack_n, 1'b1);
         check("iack_dout_oe", dout_oe, 1'b0);
      end
      release_bus();

      // Unselected cycle held for 20 clocks.
      fc    = 3'($urandom_range(0, 6));
      cs    = 1'b0;
      uds_n = 1'b0;
      lds_n = 1'b0;
      as_n  = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         check("unsel_berr",    berr,    (n >= TMO));
         check("unsel_dtack_n", dtack_n, 1'b1);
         check("unsel_mem_req", mem_req, 1'b0);
      end
      release_bus();

      // Abort: as_n rises in REQ, backend acks five clocks later.
      ack_dly_g = 4;
      fc        = 3'd5;
      cs        = 1'b1;
      addr      = 23'h000007;
      rw_n      = 1'b1;
      uds_n     = 1'b0;
      lds_n     = 1'b0;
      as_n      = 1'b0;
      for (int n = 0; n <= 8; n++) begin
         tick();
         check("abort_mem_req", mem_req, (n >= 1 && n < 6));
         check("abort_dtack_n", dtack_n, 1'b1);
         check("abort_dout_oe", dout_oe, 1'b0);
         if (n == 1) begin
            as_n  = 1'b1;
            uds_n = 1'b1;
            lds_n = 1'b1;
            cs    = 1'b0;
         end
      end
      do_access(1'b1, 23'h000007, 2'b11, 16'h0000, 0, 0);
      release_bus();

      // Reset asserted while counting wait states.
      ack_dly_g = 0;
      fc        = 3'd1;
      cs        = 1'b1;
      addr      = 23'h00000A;
      rw_n      = 1'b1;
      uds_n     = 1'b0;
      lds_n     = 1'b0;
      as_n      = 1'b0;
      for (int n = 0; n <= 3; n++) tick();
      check("wait_dtack_n", dtack_n, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_dtack_n",  dtack_n,  1'b1);
      check("mid_rst_mem_req",  mem_req,  1'b0);
      check("mid_rst_mem_be",   mem_be,   2'b00);
      check("mid_rst_mem_addr", mem_addr, 23'd0);
      check("mid_rst_dout",     dout,     16'h0000);
      check("mid_rst_dout_oe",  dout_oe,  1'b0);
      tick();
      reset_n = 1'b1;
      do_access(1'b1, 23'h00000A, 2'b11, 16'h0000, 0, 0);
      release_bus();

      // Random mix of reads and writes.
      for (int i = 0; i < 12; i++) begin
         do_access(1'($urandom_range(0, 1)), 23'($urandom), 2'($urandom_range(1, 3)),
                   16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
         release_bus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
